// File: rtl/boot_sequencer_if.sv
// Boot sequencer control/status bundle: the start/abort/load handshake and
// GPIO inputs from the system side, and the core control and result outputs.
interface boot_sequencer_if #(
  parameter int GPIO_W   = 32,
  parameter int STATUS_W = 8,
  parameter int CNT_W    = 32
) ();
  logic                start_i;
  logic                abort_i;
  logic                load_done_i;
  logic [GPIO_W-1:0]   gpio_i;
  logic                core_rst_n_o;
  logic                load_req_o;
  logic                fetch_enable_o;
  logic                busy_o;
  logic                done_o;
  logic [1:0]          exit_code_o;
  logic [STATUS_W-1:0] status_o;
  logic [CNT_W-1:0]    cycle_cnt_o;

  // System / testbench side: drives requests, observes results
  modport master (
    output start_i, abort_i, load_done_i, gpio_i,
    input  core_rst_n_o, load_req_o, fetch_enable_o, busy_o, done_o,
           exit_code_o, status_o, cycle_cnt_o
  );

  // Sequencer side
  modport slave (
    input  start_i, abort_i, load_done_i, gpio_i,
    output core_rst_n_o, load_req_o, fetch_enable_o, busy_o, done_o,
           exit_code_o, status_o, cycle_cnt_o
  );
endinterface

// File: rtl/boot_sequencer.sv
// Boot sequencer: holds the core in reset, optionally waits for the image
// loader, delays, enables fetch, then waits for end-of-computation (EOC) on
// GPIO, a timeout or an abort, and reports an exit code. All outputs are flops.
module boot_sequencer #(
  parameter int GPIO_W     = 32,
  parameter int EOC_BIT    = 8,
  parameter int STATUS_LSB = 0,
  parameter int STATUS_W   = 8,
  parameter int RST_HOLD   = 16,
  parameter int FETCH_DLY  = 5,
  parameter int USE_LOAD   = 1,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 0
) (
  input logic              clk,
  input logic              rst,
  boot_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    LOAD = 3'd2,
    FDLY = 3'd3,
    RUN  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam int DLY_W = 32;
  localparam logic [DLY_W-1:0] HOLD_LAST = DLY_W'(RST_HOLD - 1);
  localparam logic [DLY_W-1:0] FDLY_LAST = DLY_W'((FETCH_DLY > 0) ? FETCH_DLY - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] EXIT_PASS    = 2'b00;
  localparam logic [1:0] EXIT_FAIL    = 2'b01;
  localparam logic [1:0] EXIT_ABORT   = 2'b10;
  localparam logic [1:0] EXIT_TIMEOUT = 2'b11;

  state_t              state_q, state_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          exit_q, exit_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic                load_req_q, load_req_d;
  logic                fetch_en_q, fetch_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                eoc;
  logic [STATUS_W-1:0] status_field;
  state_t              after_load;

  assign eoc          = bus.gpio_i[EOC_BIT];
  assign status_field = bus.gpio_i[STATUS_LSB +: STATUS_W];
  assign after_load   = (FETCH_DLY == 0) ? RUN : FDLY;

  // Next-state, counters and result capture; abort overrides normal flow
  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    cnt_d    = cnt_q;
    exit_d   = exit_q;
    status_d = status_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          state_d  = HOLD;
          dly_d    = '0;
          cnt_d    = '0;
          exit_d   = '0;
          status_d = '0;
        end
      end
      HOLD: begin
        if (dly_q == HOLD_LAST) begin
          dly_d   = '0;
          state_d = (USE_LOAD != 0) ? LOAD : after_load;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      LOAD: begin
        if (bus.load_done_i) begin
          dly_d   = '0;
          state_d = after_load;
        end
      end
      FDLY: begin
        if (dly_q == FDLY_LAST) begin
          state_d = RUN;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      RUN: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        if (eoc) begin
          state_d  = DONE;
          status_d = status_field;
          exit_d   = (status_field == '0) ? EXIT_PASS : EXIT_FAIL;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          state_d = DONE;
          exit_d  = EXIT_TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort_i && (state_q == HOLD || state_q == LOAD ||
                        state_q == FDLY || state_q == RUN)) begin
      state_d = DONE;
      exit_d  = EXIT_ABORT;
    end

    // Counter restarts on every RUN entry, including HOLD->RUN without FDLY
    if (state_d == RUN && state_q != RUN) begin
      cnt_d = '0;
    end
  end

  // Output decode from the next state so every output is a flop
  always_comb begin
    core_rst_n_d = (state_d == LOAD) || (state_d == FDLY) ||
                   (state_d == RUN)  || (state_d == DONE);
    load_req_d   = (state_d == LOAD);
    fetch_en_d   = (state_d == RUN);
    busy_d       = (state_d != IDLE) && (state_d != DONE);
    done_d       = (state_d == DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dly_q        <= '0;
      cnt_q        <= '0;
      exit_q       <= '0;
      status_q     <= '0;
      core_rst_n_q <= 1'b0;
      load_req_q   <= 1'b0;
      fetch_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      cnt_q        <= cnt_d;
      exit_q       <= exit_d;
      status_q     <= status_d;
      core_rst_n_q <= core_rst_n_d;
      load_req_q   <= load_req_d;
      fetch_en_q   <= fetch_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.core_rst_n_o   = core_rst_n_q;
  assign bus.load_req_o     = load_req_q;
  assign bus.fetch_enable_o = fetch_en_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.exit_code_o    = exit_q;
  assign bus.status_o       = status_q;
  assign bus.cycle_cnt_o    = cnt_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: three configurations, directed sequences, and a
// scoreboard of expected results checked whenever done_o rises.
module tb_boot_sequencer;

  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;

  always #5 clk = ~clk;

  boot_sequencer_if #(.GPIO_W(32), .STATUS_W(8), .CNT_W(32)) bif0 ();
  boot_sequencer_if #(.GPIO_W(32), .STATUS_W(8), .CNT_W(32)) bif1 ();
  boot_sequencer_if #(.GPIO_W(32), .STATUS_W(8), .CNT_W(32)) bif2 ();

  boot_sequencer u0 (.clk(clk), .rst(rst0), .bus(bif0));

  boot_sequencer #(.USE_LOAD(0), .FETCH_DLY(0)) u1 (.clk(clk), .rst(rst1), .bus(bif1));

  boot_sequencer #(.RST_HOLD(4), .FETCH_DLY(2), .TIMEOUT(50)) u2 (.clk(clk), .rst(rst2), .bus(bif2));

  typedef struct packed {
    logic [1:0]  ex;
    logic [7:0]  st;
    logic [31:0] cn;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input int i, input logic [1:0] ex, input logic [7:0] st, input logic [31:0] cn);
    exp_t e;
    e = '{ex: ex, st: st, cn: cn};
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int i, input logic done, input logic prev,
                     input logic [1:0] ex, input logic [7:0] st, input logic [31:0] cn);
    exp_t e;
    logic have;
    if (done && !prev) begin
      have = 1'b0;
      e = '0;
      case (i)
        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        n_checks++;
        $display("FAIL u%0d unexpected done: exit %0h status %0h cnt %0d with no expected result", i, ex, st, cn);
      end else begin
        chk($sformatf("u%0d exit_code", i), 64'(ex), 64'(e.ex));
        chk($sformatf("u%0d status", i),    64'(st), 64'(e.st));
        chk($sformatf("u%0d cycle_cnt", i), 64'(cn), 64'(e.cn));
      end
    end
  endtask

  logic d0p = 1'b0, d1p = 1'b0, d2p = 1'b0;

  // Scoreboard monitor: compare results on each rising done_o
  always @(negedge clk) begin
    mon(0, bif0.done_o, d0p, bif0.exit_code_o, bif0.status_o, bif0.cycle_cnt_o);
    mon(1, bif1.done_o, d1p, bif1.exit_code_o, bif1.status_o, bif1.cycle_cnt_o);
    mon(2, bif2.done_o, d2p, bif2.exit_code_o, bif2.status_o, bif2.cycle_cnt_o);
    d0p <= bif0.done_o;
    d1p <= bif1.done_o;
    d2p <= bif2.done_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_rst, first_fetch, last_fetch, first_load, last_load, first_done;
    int any_load, any_fetch;
    int done_rises[$];
    int fetch_rises[$];
    int exp_done[4];
    int exp_fetch[4];
    logic pd, pf;

    bif0.start_i = 0; bif0.abort_i = 0; bif0.load_done_i = 0; bif0.gpio_i = '0;
    bif1.start_i = 0; bif1.abort_i = 0; bif1.load_done_i = 0; bif1.gpio_i = '0;
    bif2.start_i = 0; bif2.abort_i = 0; bif2.load_done_i = 0; bif2.gpio_i = '0;

    // Reset state
    tick(); tick(); tick();
    @(negedge clk);
    chk("rst core_rst_n", 64'(bif0.core_rst_n_o), 0);
    chk("rst busy",       64'(bif0.busy_o), 0);
    chk("rst done",       64'(bif0.done_o), 0);
    chk("rst exit",       64'(bif0.exit_code_o), 0);
    chk("rst cycle_cnt",  64'(bif0.cycle_cnt_o), 0);
    chk("rst load_req",   64'(bif2.load_req_o), 0);
    chk("rst fetch",      64'(bif2.fetch_enable_o), 0);
    tick();
    // Reset beats start in the same cycle on u1
    bif1.start_i = 1;
    tick();
    bif1.start_i = 0;
    rst0 = 0; rst2 = 0;
    @(negedge clk);
    chk("rst-vs-start busy", 64'(bif1.busy_o), 0);
    rst1 = 0;
    tick();

    // u0: default configuration full sequence
    first_rst = -1; first_fetch = -1; last_fetch = -1; first_load = -1; last_load = -1; first_done = -1;
    for (int t = 0; t <= 205; t++) begin
      bif0.start_i     = (t == 0);
      bif0.load_done_i = (t == 30);
      bif0.gpio_i      = (t == 200) ? 32'h100 : 32'h0;
      if (t == 200) push(0, 2'b00, 8'h00, 32'd165);
      @(negedge clk);
      if (bif0.core_rst_n_o && first_rst < 0) first_rst = t;
      if (bif0.fetch_enable_o) begin if (first_fetch < 0) first_fetch = t; last_fetch = t; end
      if (bif0.load_req_o) begin if (first_load < 0) first_load = t; last_load = t; end
      if (bif0.done_o && first_done < 0) first_done = t;
      if (t == 5) chk("u0 busy in HOLD", 64'(bif0.busy_o), 1);
      if (t == 203) chk("u0 busy in DONE", 64'(bif0.busy_o), 0);
      tick();
    end
    bif0.start_i = 0; bif0.load_done_i = 0; bif0.gpio_i = '0;
    chk("u0 core_rst_n rise", 64'(first_rst), 17);
    chk("u0 load_req first", 64'(first_load), 17);
    chk("u0 load_req last",  64'(last_load), 30);
    chk("u0 fetch first",    64'(first_fetch), 36);
    chk("u0 fetch last",     64'(last_fetch), 200);
    chk("u0 done cycle",     64'(first_done), 201);

    // u1: abort in IDLE is ignored
    bif1.abort_i = 1;
    tick(); tick();
    @(negedge clk);
    chk("u1 idle-abort busy", 64'(bif1.busy_o), 0);
    chk("u1 idle-abort done", 64'(bif1.done_o), 0);
    bif1.abort_i = 0;
    tick();

    // u1: standalone, no fetch delay, EOC with nonzero status on RUN entry
    any_load = 0; first_fetch = -1; first_done = -1;
    for (int t = 0; t <= 25; t++) begin
      bif1.start_i = (t == 0);
      bif1.abort_i = (t == 20);
      bif1.gpio_i  = (t == 17) ? 32'h103 : 32'h0;
      if (t == 17) push(1, 2'b01, 8'h03, 32'd1);
      @(negedge clk);
      if (bif1.load_req_o) any_load = 1;
      if (bif1.fetch_enable_o && first_fetch < 0) first_fetch = t;
      if (bif1.done_o && first_done < 0) first_done = t;
      tick();
    end
    bif1.start_i = 0; bif1.abort_i = 0; bif1.gpio_i = '0;
    chk("u1 load_req never", 64'(any_load), 0);
    chk("u1 fetch first",    64'(first_fetch), 17);
    chk("u1 done cycle",     64'(first_done), 18);
    chk("u1 done-abort exit held", 64'(bif1.exit_code_o), 64'(2'b01));

    // u2: timeout, EOC at the timeout cycle, abort in LOAD, reset mid-RUN
    push(2, 2'b11, 8'h00, 32'd50);
    pd = 1'b0; pf = 1'b0; any_fetch = 0;
    for (int t = 0; t <= 175; t++) begin
      bif2.start_i     = (t == 0) || (t == 60) || (t == 62) || (t == 120) ||
                         (t == 135) || (t == 153) || (t == 155);
      bif2.load_done_i = (t == 5) || (t == 65) || (t == 140) || (t == 158);
      bif2.abort_i     = (t == 127);
      bif2.gpio_i      = (t == 117) ? 32'h105 : (t == 170) ? 32'h100 : 32'h0;
      rst2             = (t == 150);
      if (t == 117) push(2, 2'b01, 8'h05, 32'd50);
      if (t == 127) push(2, 2'b10, 8'h00, 32'd0);
      if (t == 170) push(2, 2'b00, 8'h00, 32'd10);
      @(negedge clk);
      if (bif2.done_o && !pd) done_rises.push_back(t);
      if (bif2.fetch_enable_o && !pf) fetch_rises.push_back(t);
      pd = bif2.done_o;
      pf = bif2.fetch_enable_o;
      if (t >= 119 && t <= 135 && bif2.fetch_enable_o) any_fetch = 1;
      if (t == 5) chk("u2 load_req first LOAD", 64'(bif2.load_req_o), 1);
      if (t == 121) begin
        chk("u2 restart done",   64'(bif2.done_o), 0);
        chk("u2 restart exit",   64'(bif2.exit_code_o), 0);
        chk("u2 restart status", 64'(bif2.status_o), 0);
        chk("u2 restart cnt",    64'(bif2.cycle_cnt_o), 0);
        chk("u2 restart busy",   64'(bif2.busy_o), 1);
      end
      if (t == 128) chk("u2 abort load_req", 64'(bif2.load_req_o), 0);
      if (t == 151) begin
        chk("u2 midrun-rst core_rst_n", 64'(bif2.core_rst_n_o), 0);
        chk("u2 midrun-rst fetch",      64'(bif2.fetch_enable_o), 0);
        chk("u2 midrun-rst busy",       64'(bif2.busy_o), 0);
        chk("u2 midrun-rst done",       64'(bif2.done_o), 0);
        chk("u2 midrun-rst cnt",        64'(bif2.cycle_cnt_o), 0);
        chk("u2 midrun-rst load_req",   64'(bif2.load_req_o), 0);
      end
      tick();
    end
    bif2.start_i = 0; bif2.load_done_i = 0; bif2.abort_i = 0; bif2.gpio_i = '0;
    rst2 = 0;
    exp_done  = '{58, 118, 128, 171};
    exp_fetch = '{8, 68, 143, 161};
    chk("u2 done rise count", 64'(done_rises.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < done_rises.size()) chk($sformatf("u2 done rise %0d", i), 64'(done_rises[i]), 64'(exp_done[i]));
    end
    chk("u2 fetch rise count", 64'(fetch_rises.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < fetch_rises.size()) chk($sformatf("u2 fetch rise %0d", i), 64'(fetch_rises[i]), 64'(exp_fetch[i]));
    end
    chk("u2 no fetch around abort", 64'(any_fetch), 0);

    tick(); tick();
    chk("u0 results pending", 64'(q0.size()), 0);
    chk("u1 results pending", 64'(q1.size()), 0);
    chk("u2 results pending", 64'(q2.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
